// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial LSB-first WIDTH-bit subtractor with start/busy/done handshake
// Optional signed overflow output ovf enabled by defining SERSUB_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             borrow;
  logic [CW-1:0]    cnt;

  logic a0, b0, hd, hb, d, bn, last;

  // Full subtractor: two half subtractors chained, borrows ORed.
  always_comb begin
    a0   = a_sh[0];
    b0   = b_sh[0];
    hd   = a0 ^ b0;
    hb   = ~a0 & b0;
    d    = hd ^ borrow;
    bn   = hb | (~hd & borrow);
    last = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            borrow <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b1;
            diff   <= '0;
            bout   <= 1'b0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          diff   <= {d, diff[WIDTH-1:1]};
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          borrow <= bn;
          cnt    <= cnt + 1'b1;
          if (last) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            bout  <= bn;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SERSUB_OVF_EN
  logic a_msb, b_msb;

  // The final bit shifted in is the result MSB, so overflow is decided on the last edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        a_msb <= a[WIDTH-1];
        b_msb <= b[WIDTH-1];
        ovf   <= 1'b0;
      end
    end else if (last) begin
      ovf <= (a_msb != b_msb) && (d != a_msb);
    end
  end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor (ovf checked when SERSUB_OVF_EN is defined)
module tb_serial_subtractor;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy, done, bout;
  logic [WIDTH-1:0] diff;
`ifdef SERSUB_OVF_EN
  logic             ovf;
`endif

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SERSUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    int               due;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  function automatic void chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Reference: plain unsigned/signed integer arithmetic on the operands.
  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input int due);
    exp_t m;
    int   sx, sy, r;
    m.diff = WIDTH'(int'(x) - int'(y));
    m.bout = (x < y);
    sx     = $signed(x);
    sy     = $signed(y);
    r      = sx - sy;
    m.ovf  = (r > (2 ** (WIDTH - 1)) - 1) || (r < -(2 ** (WIDTH - 1)));
    m.due  = due;
    return m;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("diff", diff, e.diff);
          chk("bout", bout, e.bout);
          chk("done_cycle", cyc, e.due);
          chk("busy_at_done", busy, 0);
`ifdef SERSUB_OVF_EN
          chk("ovf", ovf, e.ovf);
`endif
        end
      end else if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
        chk("done_timeout", cyc, exp_q[0].due);
        void'(exp_q.pop_front());
      end
    end
  end

  // Called at a negedge with the DUT idle (or in its done cycle); returns at the done-cycle negedge.
  task automatic issue(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib, input bit hold);
    start = 1'b1;
    a     = ia;
    b     = ib;
    @(negedge clk);
    exp_q.push_back(model(ia, ib, cyc + WIDTH));
    if (hold) begin
      for (int i = 0; i < WIDTH; i++) begin
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        @(negedge clk);
      end
      start = 1'b0;
    end else begin
      start = 1'b0;
      a     = WIDTH'($urandom);
      b     = WIDTH'($urandom);
      repeat (WIDTH) @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
`ifdef SERSUB_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    issue(8'd5, 8'd3, 1'b0);
    @(negedge clk);
    issue(8'd3, 8'd5, 1'b0);
    @(negedge clk);
    issue(8'h00, 8'h00, 1'b0);
    @(negedge clk);
    issue(8'hFF, 8'hFF, 1'b0);
    @(negedge clk);
    issue(8'h00, 8'h01, 1'b0);
    @(negedge clk);
    issue(8'h5A, 8'h33, 1'b1);
    @(negedge clk);
    chk("no_extra_op_busy", busy, 0);
    issue(8'h80, 8'h01, 1'b0);
    issue(8'h10, 8'h01, 1'b0);
    issue(8'h7F, 8'h01, 1'b0);
    @(negedge clk);

    // Abort: reset sampled on the 4th shift edge.
    start = 1'b1;
    a     = 8'hAA;
    b     = 8'h55;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_diff", diff, 0);
    chk("abort_done", done, 0);
    chk("abort_bout", bout, 0);
    rst_n = 1'b1;
    repeat (WIDTH + 3) @(negedge clk);

    for (int n = 0; n < 24; n++) begin
      int gap;
      gap = $urandom_range(0, 2);
      if (gap > 0) repeat (gap) @(negedge clk);
      issue(WIDTH'($urandom), WIDTH'($urandom), $urandom_range(0, 3) == 0);
    end

    repeat (WIDTH + 3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial WIDTH-bit subtractor that computes A - B LSB-first, one bit per clock.
Each step uses a full-subtractor cell (two half subtractors plus an OR on the borrows) and a registered borrow carried between steps.
It sits directly downstream of the combinational half/full subtractor cells and reuses their diff/borrow equations in a sequential datapath.
A start/busy/done handshake lets a controller or testbench issue back-to-back operations.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 2..32)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  reset, synchronous, active-low
start  input  1  request a subtraction; sampled only in IDLE
a  input  WIDTH  minuend; captured on the accepted start edge
b  input  WIDTH  subtrahend; captured on the accepted start edge
busy  output  1  high while a subtraction is in progress
done  output  1  one-cycle pulse; diff/bout valid from this cycle
diff  output  WIDTH  result (a - b) mod 2^WIDTH; held until the next accepted start
bout  output  1  final borrow; 1 when a < b (unsigned); held with diff

Behaviour:
- Clock and reset: single clock clk. rst_n is synchronous and active-low: it takes effect only on a rising clk edge while rst_n = 0.
- Reset values: state = IDLE; busy = 0; done = 0; diff = 0; bout = 0; internal shift registers, borrow register and bit counter = 0.
- FSM states: IDLE and SHIFT.
- IDLE, start = 1 at edge k:
  - load a_sh <= a, b_sh <= b, borrow <= 0, cnt <= 0, busy <= 1, state <= SHIFT;
  - clear diff and bout; done <= 0.
- IDLE, start = 0: hold all outputs; done <= 0.
- SHIFT, each edge, with a0 = a_sh[0], b0 = b_sh[0], br = borrow:
  - d = a0 ^ b0 ^ br;
  - bn = (~a0 & b0) | (~(a0 ^ b0) & br);
  - diff <= {d, diff[WIDTH-1:1]};
  - a_sh and b_sh shift right by 1 (zero fill);
  - borrow <= bn; cnt <= cnt + 1.
- SHIFT, edge where cnt = WIDTH-1 (the last bit): additionally state <= IDLE, busy <= 0, done <= 1, bout <= bn.
- Latency: start accepted at edge k; shift edges are k+1 .. k+WIDTH; done is high during the cycle after edge k+WIDTH, a WIDTH-cycle latency.
- done is high for exactly one cycle. A start presented in that cycle is accepted, so back-to-back throughput is one result per WIDTH+1 cycles.
- start while busy = 1 is ignored; the operands are not re-sampled and the running operation completes unaffected.
- Changing a/b while busy has no effect.
- diff is not meaningful while busy (partial shift contents); it is valid only from done onward.
- Reset mid-operation: on an edge with rst_n = 0 the block returns to the reset values; no done is produced for the aborted operation.
- Counter width: $clog2(WIDTH) + 1 bits; it never wraps within an operation.

Optional Feature:
Macro SERSUB_OVF_EN.
- Defined: adds output port ovf (output, 1 bit), the signed two's-complement overflow flag.
  - ovf = (a_msb != b_msb) && (diff_msb != a_msb), using the captured operand MSBs.
  - Registered on the same edge as done and held with diff; reset value 0; cleared on an accepted start.
- Undefined: no ovf port and no related logic; all other behaviour is identical.

Test Plan:
- Reset then idle: hold rst_n = 0 for 2 edges, start = 0 -> busy = 0, done = 0, diff = 0x00, bout = 0.
- Basic subtract, WIDTH = 8: a = 5, b = 3, pulse start -> done exactly 8 cycles after the accept edge; diff = 0x02, bout = 0, single-cycle done.
- Underflow: a = 3, b = 5 -> diff = 0xFE, bout = 1. Edge cases: a = 0x00, b = 0x00 -> diff = 0x00, bout = 0; a = 0xFF, b = 0xFF -> diff = 0x00, bout = 0; a = 0x00, b = 0x01 -> diff = 0xFF, bout = 1.
- Handshake:
  - start held high and a/b changed while busy -> original result still produced, with no extra operation until IDLE;
  - start asserted in the done cycle with a = 0x10, b = 0x01 -> second result diff = 0x0F, done 9 cycles after the first done.
- Reset mid-op: start with a = 0xAA, b = 0x55; drive rst_n = 0 at shift edge 4 -> next cycle busy = 0, diff = 0, and no done pulse.
- With SERSUB_OVF_EN: a = 0x80, b = 0x01 -> diff = 0x7F, bout = 0, ovf = 1; a = 0x7F, b = 0x01 -> diff = 0x7E, ovf = 0. Also compile without the macro and rerun the basic tests.
